dmem_lsu: RTL and testbench
===========================

Name: dmem_lsu

Overview:
- Load/store unit directly downstream of the single-cycle ARM datapath.
- Consumes the datapath's ALUResult (address), WriteData and the controller's MemWrite/MemtoReg. Returns ReadData to the datapath's result mux.
- Contains the word-addressed data RAM (synchronous read) and a small memory-mapped I/O block: LEDs, switches, cycle counter.
- Asserts Stall during load latency so the controller can freeze PC and register-file writes.

Parameters:
DEPTH, 256, RAM size in 32-bit words; power of two; RAM occupies byte addresses 0x0000_0000..DEPTH*4-1
LED_W, 8, width of LED output register
SW_W, 8, width of switch input

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
MemWrite  input  1  store request (STR/STRB)
MemRead  input  1  load request (driven from MemtoReg)
Byte  input  1  1 = byte access (LDRB/STRB), 0 = word
Addr  input  32  byte address (datapath ALUResult)
WriteData  input  32  store data
ReadData  output  32  load result to datapath result mux
Stall  output  1  1 = hold PC and suppress RegWrite this cycle
sw_in  input  SW_W  asynchronous switch inputs
led_out  output  LED_W  LED register
err  output  1  sticky access-error flag

Behaviour:
Reset (asynchronous, reset=0):
- FSM to IDLE; Stall=0, ReadData=0, led_out=0, counter=0, switch sync flops=0, err=0.
- RAM contents are not cleared.
- Reset asserted mid-load aborts the load; no ReadData update.

Address map:
- RAM: Addr < DEPTH*4; word index Addr[log2(DEPTH)+1:2].
- 0xFFFF_0000 LED: read/write; low LED_W bits; reads zero-extended.
- 0xFFFF_0004 SW: read-only; 2-flop synchronized sw_in, zero-extended; writes ignored and set err.
- 0xFFFF_0008 CNT: 32-bit free-running cycle counter, +1 every cycle, wraps 0xFFFF_FFFF->0. A store clears it (value 0 after the edge, +1 per cycle thereafter).
- Any other address is unmapped: reads return 0, writes are ignored, err is set.

FSM states: IDLE, RD_WAIT.
- IDLE, MemRead=1, MemWrite=0: sample Addr/Byte; issue RAM read or capture MMIO value. Stall=1 combinationally this cycle. Next state RD_WAIT.
- RD_WAIT:
  - ReadData updated from RAM output (or captured MMIO value), formatted per Byte. Stall=0, so ReadData is valid for the datapath in this cycle.
  - The request still asserted in this cycle must not re-issue. Next state IDLE unconditionally.
- Load latency: 2 cycles per load instruction (1 stall cycle).
- ReadData holds its last value until the next load completes.
- Stores: performed at the clock edge in IDLE, 0 stall cycles; Stall=0.
- MemWrite=1 and MemRead=1 together: store performed, no load issued, err set.

Width and byte rules:
- Little-endian.
- Byte load: zero-extend lane Addr[1:0] into ReadData[7:0].
- Byte store: write WriteData[7:0] into lane Addr[1:0] only; other lanes unchanged.
- Word access with Addr[1:0]!=0: low bits ignored (aligned access performed); err set.
- Byte access to any MMIO address: err set, write ignored, read returns 0.

err:
- Sticky; set at the edge ending the offending cycle; cleared only by reset.

Test Plan:
- Reset released, STR 0xDEADBEEF to 0x10, then LDR 0x10 -> Stall=1 for exactly one cycle; ReadData=0xDEADBEEF in the next cycle with Stall=0; err=0.
- STRB 0xAA to 0x13 over word 0x11223344, then LDR 0x10 -> 0xAA223344. LDRB 0x12 -> 0x00000022.
- STR 0x1A5 to 0xFFFF_0000 -> led_out=0xA5. With sw_in=0x3C stable for 2 cycles, LDR 0xFFFF_0004 -> 0x0000003C.
- STR to 0xFFFF_0008, wait 10 cycles, LDR 0xFFFF_0008 -> value equals cycles elapsed between the store edge and the load issue edge (10 ±0, checked exactly by the model). LDR 0x4000 (unmapped) -> ReadData=0, err=1 and stays 1.
- LDR word at 0x22 -> returns word at 0x20; err=1. MemRead and MemWrite together -> store happens, Stall=0, err=1.
- Assert reset during RD_WAIT -> Stall=0, ReadData=0, led_out=0 immediately. A subsequent LDR of a previously written RAM word returns the original data.

Source files
------------

// File: rtl/dmem_lsu.sv
// dmem_lsu: load/store unit for the single-cycle ARM datapath.
// Holds the word-addressed data RAM (synchronous read) and a small MMIO block
// (LED register, synchronized switches, free-running cycle counter).
// Loads take two cycles: the issue cycle raises Stall, and the following cycle
// (RD_WAIT) presents ReadData with Stall low. Stores complete in one cycle.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   MemWrite   store request (STR/STRB)
//   MemRead    load request
//   Byte       1 = byte access, 0 = word access
//   Addr       byte address
//   WriteData  store data
//   ReadData   load result (valid in RD_WAIT, held until the next load)
//   Stall      hold PC / suppress RegWrite this cycle
//   sw_in      asynchronous switch inputs
//   led_out    LED register
//   err        sticky access-error flag
module dmem_lsu #(
  parameter int DEPTH = 256,
  parameter int LED_W = 8,
  parameter int SW_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             MemWrite,
  input  logic             MemRead,
  input  logic             Byte,
  input  logic [31:0]      Addr,
  input  logic [31:0]      WriteData,
  output logic [31:0]      ReadData,
  output logic             Stall,
  input  logic [SW_W-1:0]  sw_in,
  output logic [LED_W-1:0] led_out,
  output logic             err
);

  localparam int AW = $clog2(DEPTH);
  // Word addresses (Addr[31:2]) of the MMIO registers at 0xFFFF_0000/4/8.
  localparam logic [29:0] LED_WA = 30'h3FFF_C000;
  localparam logic [29:0] SW_WA  = 30'h3FFF_C001;
  localparam logic [29:0] CNT_WA = 30'h3FFF_C002;

  typedef enum logic {IDLE, RD_WAIT} state_t;
  state_t state;

  logic [31:0]      mem [DEPTH];
  logic [LED_W-1:0] led_q;
  logic [SW_W-1:0]  sw_s1, sw_s2;
  logic [31:0]      cnt_q;
  logic [31:0]      rd_hold;

  function automatic logic [31:0] fmt_load(input logic [31:0] w,
                                           input logic [1:0]  lane,
                                           input logic        byte_en);
    if (byte_en) return {24'h0, w[{lane, 3'b000} +: 8]};
    return w;
  endfunction

  // ---- p0: request decode in the issue cycle ----
  logic [AW-1:0] idx_p0;
  logic [1:0]    lane_p0;
  logic          hit_ram_p0, hit_led_p0, hit_sw_p0, hit_cnt_p0, hit_mmio_p0;
  logic          act_p0, wr_p0, vld_p0, bad_p0;
  logic [31:0]   mmio_val_p0;

  assign idx_p0      = Addr[AW+1:2];
  assign lane_p0     = Addr[1:0];
  assign hit_ram_p0  = (Addr[31:AW+2] == '0);
  assign hit_led_p0  = (Addr[31:2] == LED_WA);
  assign hit_sw_p0   = (Addr[31:2] == SW_WA);
  assign hit_cnt_p0  = (Addr[31:2] == CNT_WA);
  assign hit_mmio_p0 = hit_led_p0 | hit_sw_p0 | hit_cnt_p0;

  // Requests are only honoured in IDLE; the load still held during RD_WAIT
  // must not re-issue. Gating with reset keeps Stall low while in reset.
  assign act_p0 = reset && (state == IDLE);
  assign wr_p0  = act_p0 && MemWrite;
  assign vld_p0 = act_p0 && MemRead && !MemWrite;
  assign Stall  = vld_p0;

  assign bad_p0 = act_p0 && (MemWrite || MemRead) &&
                  ((MemWrite && MemRead) ||
                   (!Byte && (lane_p0 != 2'b00)) ||
                   (Byte && hit_mmio_p0) ||
                   (!hit_ram_p0 && !hit_mmio_p0) ||
                   (MemWrite && hit_sw_p0));

  // The counter value returned is the one it takes at the issue edge, i.e. the
  // number of edges since the clearing store.
  always_comb begin
    mmio_val_p0 = 32'h0;
    if (!Byte) begin
      if (hit_led_p0)      mmio_val_p0 = 32'(led_q);
      else if (hit_sw_p0)  mmio_val_p0 = 32'(sw_s2);
      else if (hit_cnt_p0) mmio_val_p0 = cnt_q + 32'd1;
    end
  end

  // ---- p1: RAM read register and captured load attributes ----
  logic [31:0] ram_q_p1, ld_mmio_p1;
  logic [1:0]  ld_lane_p1;
  logic        ld_byte_p1, ld_ram_p1, vld_p1;

  always_ff @(posedge clk) begin
    if (wr_p0 && hit_ram_p0) begin
      if (Byte) mem[idx_p0][{lane_p0, 3'b000} +: 8] <= WriteData[7:0];
      else      mem[idx_p0] <= WriteData;
    end
    if (vld_p0) begin
      ram_q_p1   <= mem[idx_p0];
      ld_mmio_p1 <= mmio_val_p0;
      ld_lane_p1 <= lane_p0;
      ld_byte_p1 <= Byte;
      ld_ram_p1  <= hit_ram_p0;
    end
  end

  logic [31:0] rd_fmt_p1;
  assign vld_p1    = (state == RD_WAIT);
  assign rd_fmt_p1 = ld_ram_p1 ? fmt_load(ram_q_p1, ld_lane_p1, ld_byte_p1) : ld_mmio_p1;
  assign ReadData  = vld_p1 ? rd_fmt_p1 : rd_hold;
  assign led_out   = led_q;

  // ---- control state, MMIO registers, error flag ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      rd_hold <= 32'h0;
      led_q   <= '0;
      sw_s1   <= '0;
      sw_s2   <= '0;
      cnt_q   <= 32'h0;
      err     <= 1'b0;
    end else begin
      sw_s1 <= sw_in;
      sw_s2 <= sw_s1;

      if (wr_p0 && hit_cnt_p0 && !Byte) cnt_q <= 32'h0;
      else                              cnt_q <= cnt_q + 32'd1;

      if (wr_p0 && hit_led_p0 && !Byte) led_q <= WriteData[LED_W-1:0];

      if (bad_p0) err <= 1'b1;

      case (state)
        IDLE:    if (vld_p0) state <= RD_WAIT;
        RD_WAIT: begin
          rd_hold <= rd_fmt_p1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Testbench for dmem_lsu: directed load/store sequences with a scoreboard of
// expected load results, popped by a monitor in the cycle after each stall.
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic        Byte = 1'b0;
  logic [31:0] Addr = 32'h0;
  logic [31:0] WriteData = 32'h0;
  logic [31:0] ReadData;
  logic        Stall;
  logic [7:0]  sw_in = 8'h0;
  logic [7:0]  led_out;
  logic        err;

  dmem_lsu #(.DEPTH(256), .LED_W(8), .SW_W(8)) dut (
    .clk(clk), .reset(reset), .MemWrite(MemWrite), .MemRead(MemRead),
    .Byte(Byte), .Addr(Addr), .WriteData(WriteData), .ReadData(ReadData),
    .Stall(Stall), .sw_in(sw_in), .led_out(led_out), .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [31:0] sb[$];
  logic        prev_stall = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Monitor: the cycle after a stall is the load's data cycle.
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_rdwait", {31'h0, Stall}, 32'h0);
        chk("sb_depth", 32'(sb.size()), 32'd1);
        if (sb.size() > 0) chk("rdata", ReadData, sb.pop_front());
      end
      prev_stall = Stall;
    end
  end

  task automatic nop();
    @(posedge clk); #2;
    MemWrite = 1'b0; MemRead = 1'b0; Byte = 1'b0;
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input logic b);
    @(posedge clk); #2;
    MemWrite = 1'b1; MemRead = 1'b0; Byte = b; Addr = a; WriteData = d;
  endtask

  task automatic load(input logic [31:0] a, input logic b, input logic [31:0] exp);
    @(posedge clk); #2;
    MemWrite = 1'b0; MemRead = 1'b1; Byte = b; Addr = a;
    sb.push_back(exp);
    @(negedge clk);
    chk("stall_issue", {31'h0, Stall}, 32'h1);
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    MemWrite = 1'b0; MemRead = 1'b0; Byte = 1'b0;
    reset = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  int s_edge;
  int exp_cnt;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", {31'h0, Stall}, 32'h0);
    chk("rst_rdata", ReadData, 32'h0);
    chk("rst_led", {24'h0, led_out}, 32'h0);
    chk("rst_err", {31'h0, err}, 32'h0);
    @(posedge clk); #2;
    reset = 1'b1;

    // Word store/load
    store(32'h10, 32'hDEADBEEF, 1'b0);
    load(32'h10, 1'b0, 32'hDEADBEEF);
    nop();
    chk("rdata_hold", ReadData, 32'hDEADBEEF);
    chk("err_clean", {31'h0, err}, 32'h0);

    // Byte lanes
    store(32'h10, 32'h11223344, 1'b0);
    store(32'h13, 32'h555555AA, 1'b1);
    load(32'h10, 1'b0, 32'hAA223344);
    load(32'h12, 1'b1, 32'h00000022);
    load(32'h13, 1'b1, 32'h000000AA);
    load(32'h10, 1'b1, 32'h00000044);
    nop();
    chk("err_bytes", {31'h0, err}, 32'h0);

    // LED and switches
    store(32'hFFFF_0000, 32'h0000_01A5, 1'b0);
    nop();
    chk("led", {24'h0, led_out}, 32'h000000A5);
    sw_in = 8'h3C;
    nop(); nop(); nop();
    load(32'hFFFF_0004, 1'b0, 32'h0000003C);
    load(32'hFFFF_0000, 1'b0, 32'h000000A5);

    // Cycle counter
    store(32'hFFFF_0008, 32'h1234_5678, 1'b0);
    s_edge = cyc + 1;
    repeat (9) nop();
    @(posedge clk); #2;
    exp_cnt = (cyc + 1) - s_edge;
    MemWrite = 1'b0; MemRead = 1'b1; Byte = 1'b0; Addr = 32'hFFFF_0008;
    sb.push_back(32'(exp_cnt));
    @(negedge clk);
    chk("stall_issue", {31'h0, Stall}, 32'h1);
    @(posedge clk); #2;
    nop();
    chk("err_cnt", {31'h0, err}, 32'h0);

    // Unmapped load
    load(32'h0000_4000, 1'b0, 32'h0);
    chk("err_unmapped", {31'h0, err}, 32'h1);
    nop(); nop(); nop();
    chk("err_sticky", {31'h0, err}, 32'h1);

    // Misaligned word load
    do_reset();
    chk("err_after_rst", {31'h0, err}, 32'h0);
    store(32'h20, 32'hCAFEF00D, 1'b0);
    load(32'h22, 1'b0, 32'hCAFEF00D);
    chk("err_misalign", {31'h0, err}, 32'h1);

    // Read and write together
    do_reset();
    @(posedge clk); #2;
    MemWrite = 1'b1; MemRead = 1'b1; Byte = 1'b0; Addr = 32'h30; WriteData = 32'h0BADC0DE;
    @(negedge clk);
    chk("stall_rw", {31'h0, Stall}, 32'h0);
    nop();
    chk("err_rw", {31'h0, err}, 32'h1);
    load(32'h30, 1'b0, 32'h0BADC0DE);

    // Byte access to MMIO
    do_reset();
    store(32'hFFFF_0000, 32'h0000_005A, 1'b0);
    nop();
    chk("err_led_word", {31'h0, err}, 32'h0);
    store(32'hFFFF_0000, 32'h0000_0077, 1'b1);
    nop();
    chk("led_byte_ign", {24'h0, led_out}, 32'h0000005A);
    chk("err_mmio_byte", {31'h0, err}, 32'h1);
    load(32'hFFFF_0000, 1'b1, 32'h0);

    // Reset during RD_WAIT
    nop();
    @(posedge clk); #2;
    MemRead = 1'b1; Byte = 1'b0; Addr = 32'h10;
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("abort_stall", {31'h0, Stall}, 32'h0);
    chk("abort_rdata", ReadData, 32'h0);
    chk("abort_led", {24'h0, led_out}, 32'h0);
    MemRead = 1'b0;
    @(posedge clk); #2;
    reset = 1'b1;
    load(32'h10, 1'b0, 32'hAA223344);
    nop(); nop();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
